// File: rtl/instr_register_pkg.sv
// rtl/instr_register_pkg.sv - shared instruction, request and grant types
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } req_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/instr_register_ctrl_rr_arbiter2.sv
// rtl/instr_register_ctrl_rr_arbiter2.sv - two-way round-robin grant selection
module rr_arbiter2
  import instr_register_pkg::*;
(
  input  logic   valid_a,
  input  logic   valid_b,
  input  grant_t last_grant,
  output logic   grant_a,
  output logic   grant_b
);

  // A lone requester always wins; on a tie the one not granted last wins.
  assign grant_a = valid_a && (!valid_b || (last_grant == GRANT_B));
  assign grant_b = valid_b && (!valid_a || (last_grant == GRANT_A));

endmodule

// File: rtl/instr_register_ctrl.sv
// rtl/instr_register_ctrl.sv - two-requester instruction register write/read controller
// Defining INSTR_CTRL_STATS_EN adds saturating per-requester grant counters.
module instr_register_ctrl
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_a_valid,
  input  req_t             req_a_data,
  output logic             req_a_ready,
  input  logic             req_b_valid,
  input  req_t             req_b_data,
  output logic             req_b_ready,
  output logic             load_en,
  output logic [PTR_W-1:0] write_pointer,
  output opcode_t          opcode,
  output operand_t         operand_a,
  output operand_t         operand_b,
  output logic [PTR_W-1:0] read_pointer,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PTR_W:0]   count,
`ifdef INSTR_CTRL_STATS_EN
  output logic [15:0]      grant_a_cnt,
  output logic [15:0]      grant_b_cnt,
`endif
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic             grant_a, grant_b, xfer_a, xfer_b, xfer, pop;
  grant_t           last_grant_q, last_grant_d;
  logic             load_en_q, load_en_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic [PTR_W-1:0] write_pointer_q, write_pointer_d;
  logic [PTR_W-1:0] read_pointer_q, read_pointer_d;
  logic [PTR_W:0]   count_q, count_d;
  req_t             payload_q, payload_d;

  rr_arbiter2 u_arb (
    .valid_a    (req_a_valid),
    .valid_b    (req_b_valid),
    .last_grant (last_grant_q),
    .grant_a    (grant_a),
    .grant_b    (grant_b)
  );

  // A write still in the load stage already owns a slot, so it counts toward full.
  assign full     = (count_q + {{PTR_W{1'b0}}, load_en_q}) == DEPTH_CNT;
  assign empty    = (count_q == '0);
  assign rd_valid = !empty;

  assign req_a_ready = reset_n && !full && grant_a;
  assign req_b_ready = reset_n && !full && grant_b;
  assign xfer_a      = req_a_ready;
  assign xfer_b      = req_b_ready;
  assign xfer        = xfer_a || xfer_b;
  assign pop         = rd_valid && rd_ready;

  always_comb begin
    last_grant_d    = last_grant_q;
    load_en_d       = xfer;
    wr_idx_d        = wr_idx_q;
    write_pointer_d = write_pointer_q;
    read_pointer_d  = read_pointer_q;
    payload_d       = payload_q;
    count_d         = count_q + {{PTR_W{1'b0}}, load_en_q} - {{PTR_W{1'b0}}, pop};
    if (xfer) begin
      last_grant_d    = xfer_a ? GRANT_A : GRANT_B;
      write_pointer_d = wr_idx_q;
      wr_idx_d        = wr_idx_q + PTR_W'(1);
      payload_d       = xfer_a ? req_a_data : req_b_data;
    end
    if (pop) begin
      read_pointer_d = read_pointer_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q    <= GRANT_B;
      load_en_q       <= 1'b0;
      wr_idx_q        <= '0;
      write_pointer_q <= '0;
      read_pointer_q  <= '0;
      count_q         <= '0;
      payload_q       <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      load_en_q       <= load_en_d;
      wr_idx_q        <= wr_idx_d;
      write_pointer_q <= write_pointer_d;
      read_pointer_q  <= read_pointer_d;
      count_q         <= count_d;
      payload_q       <= payload_d;
    end
  end

  assign load_en       = load_en_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = read_pointer_q;
  assign count         = count_q;
  assign opcode        = payload_q.opc;
  assign operand_a     = payload_q.op_a;
  assign operand_b     = payload_q.op_b;

`ifdef INSTR_CTRL_STATS_EN
  logic [15:0] grant_a_cnt_q, grant_b_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_a_cnt_q <= '0;
      grant_b_cnt_q <= '0;
    end else begin
      if (xfer_a && (grant_a_cnt_q != 16'hFFFF)) grant_a_cnt_q <= grant_a_cnt_q + 16'd1;
      if (xfer_b && (grant_b_cnt_q != 16'hFFFF)) grant_b_cnt_q <= grant_b_cnt_q + 16'd1;
    end
  end

  assign grant_a_cnt = grant_a_cnt_q;
  assign grant_b_cnt = grant_b_cnt_q;
`endif

endmodule

// File: doc/instr_register_ctrl.md
INSTR_REGISTER_CTRL -- requirements
Module: instr_register_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, number of instruction register entries; SHALL be a power of two.
REQ-002 Parameter PTR_W, default 5, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port clk  input  1  single clock; all flops on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_a_valid / req_b_valid  input  1 each  requester A/B has an instruction to write.
REQ-006 Port req_a_data / req_b_data  input  req_t each  opcode, operand_a, operand_b from requester A/B.
REQ-007 Port req_a_ready / req_b_ready  output  1 each  requester A/B transfer accepted this cycle.
REQ-008 Port load_en  output  1  write strobe to instruction register.
REQ-009 Port write_pointer  output  PTR_W  register write address.
REQ-010 Port opcode, operand_a, operand_b  output  opcode_t, operand_t, operand_t  registered write payload.
REQ-011 Port read_pointer  output  PTR_W  register read address; consumer takes instruction_word from the register.
REQ-012 Port rd_valid  output  1  entry at read_pointer holds committed data.
REQ-013 Port rd_ready  input  1  consumer pops entry at read_pointer.
REQ-014 Port count  output  PTR_W+1  committed entries, 0..DEPTH.
REQ-015 Port full, empty  output  1 each  occupancy flags.

Function
REQ-016 Transfer on requester X SHALL occur at a rising edge where req_X_valid and req_X_ready are both 1.
REQ-017 req_X_ready SHALL be combinational: 1 only when !full, req_X_valid, and X wins arbitration; at most one ready high per cycle.
REQ-018 Arbitration SHALL be round-robin: one valid requester wins alone; both valid, the requester not granted last wins; last_grant SHALL update on each transfer only.
REQ-019 Transfer at edge N SHALL drive load_en=1, write_pointer=current write index and payload=accepted req_t during cycle N..N+1; load_en SHALL be 0 in cycles with no transfer.
REQ-020 Write index SHALL increment by 1 modulo DEPTH after each transfer (31 wraps to 0).
REQ-021 count SHALL increment at each edge where load_en is 1 (register capture) and decrement at each pop; both together leave count unchanged.
REQ-022 full SHALL equal (count + load_en == DEPTH); empty SHALL equal (count == 0); rd_valid SHALL equal !empty.
REQ-023 Pop SHALL occur at an edge where rd_valid and rd_ready are 1; read_pointer then increments modulo DEPTH.
REQ-024 rd_ready while empty SHALL be ignored: no pointer or count change.
REQ-025 While full, no transfer SHALL occur even if a pop happens the same cycle; space frees the following cycle.
REQ-026 Payload outputs SHALL hold their last value when load_en is 0.

Reset
REQ-027 reset_n low SHALL immediately force load_en=0, write_pointer=0, read_pointer=0, write index=0, count=0, payload=0 (opcode ZERO), last_grant=B (so A wins first tie).
REQ-028 Reset mid-operation SHALL discard any in-flight write; req_X_ready SHALL be 0 while reset_n is low.

Configuration
REQ-029 Macro INSTR_CTRL_STATS_EN, when defined, SHALL add outputs grant_a_cnt and grant_b_cnt (16 bits each), counting transfers per requester, saturating at 16'hFFFF, reset to 0.
REQ-030 Without INSTR_CTRL_STATS_EN those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 req_t (opcode_t opc, operand_t op_a, operand_t op_b) SHALL be added to instr_register_pkg alongside opcode_t, operand_t, instruction_t.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs valid_a, valid_b, last_grant; outputs grant_a, grant_b).

Verification
REQ-033 Reset: reset_n low 2 cycles -> load_en=0, pointers=0, count=0, empty=1, rd_valid=0.
REQ-034 Single write: A sends {ADD,5,3} -> next cycle load_en=1, write_pointer=0, opcode=ADD; cycle after, count=1, rd_valid=1.
REQ-035 Contention: A and B valid continuously for 4 transfers -> grant order A,B,A,B at write_pointer 0,1,2,3.
REQ-036 Full: 32 transfers, no pops -> full=1, count=32, both readies 0; one pop with valid A -> A accepted next cycle, write_pointer=0 (wrap).
REQ-037 Simultaneous: count=5, transfer commit and pop on same edge -> count stays 5, read_pointer advances by 1.
REQ-038 Empty pop and mid-reset: rd_ready=1 at empty -> no change; reset_n low during load_en=1 -> load_en=0, count=0 immediately.
